propagate_adder: RTL and testbench
==================================

# propagate_adder

Registered carry-propagate adder: adds two WIDTH-bit operands plus carry-in and registers sum, carry-out, signed overflow and a group-propagate flag. It is the datapath's general-purpose adder and sits between operand-select muxes and the result/flag registers. Carries are computed with per-bit propagate/generate terms combined in 4-bit lookahead groups, which ripple between groups.

## Interface
- WIDTH, 4, operand/sum width; legal values are integers ≥ 1.

One clock; reset is synchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  registered outputs hold a new result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- carry  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- prop  output  1  &(a ^ b); set when cin propagates through every bit.

## Operation
- Per bit: p[i] = a[i]^b[i], g[i] = a[i]&b[i], sum[i] = p[i]^c[i], c[0] = cin.
- Within each 4-bit group, every carry is computed by a lookahead equation from p, g and the group carry-in. Each group's carry-out feeds the next group. A final partial group, when WIDTH is not a multiple of 4, uses the same equations truncated.
- carry = c[WIDTH]; ovf = c[WIDTH-1]^c[WIDTH]. For WIDTH = 1, ovf = cin^carry.
- All arithmetic is modulo 2^WIDTH; the full result is {carry, sum}.
- prop depends only on a and b, not on cin.
- in_valid = 1 at a rising edge: sum, carry, ovf and prop load the new result, and out_valid is set to 1.
- in_valid = 0 at a rising edge: sum, carry, ovf and prop hold their previous values, and out_valid is cleared to 0.
- No back-pressure. The block accepts one operand set per cycle, every cycle.

## Timing
- Reset: rst_n = 0 at a rising edge sets sum = 0, carry = 0, ovf = 0, prop = 0 and out_valid = 0, and discards any operands presented that cycle.
- Reset takes priority over in_valid. A result still in flight when reset is applied is lost.
- Latency is 1 cycle. Operands sampled at edge N appear on the outputs after edge N, with out_valid = 1 for that one cycle.
- Throughput is 1 result per cycle. Back-to-back valid operands produce back-to-back results in input order.
- Outputs change only on clock edges. The carry path is combinational from a, b and cin to the output flops, and its depth must fit one clock period.

## Configuration
- PROPAGATE_ADDER_IN_REG_EN defined:
  - a, b, cin and in_valid are registered first, which adds one cycle.
  - Latency becomes 2 cycles.
  - The input registers reset to 0 and in_valid is cleared on reset.
  - Hold and valid rules apply at each stage.
- PROPAGATE_ADDER_IN_REG_EN undefined: latency is 1 cycle as specified above.
- Arithmetic results are identical in both builds.

## Test plan
All scenarios use WIDTH = 4, 1-cycle build, with in_valid = 1 unless noted.
- Reset and basic adds:
  - rst_n = 0 for 2 cycles → all outputs 0.
  - Then a=0000, b=0000, cin=0 → sum=0000, carry=0, ovf=0, prop=0, out_valid=1 one cycle later.
  - a=0001, b=0010, cin=0 → sum=0011, carry=0, ovf=0.
- Carry-in and signed overflow: a=0101, b=0011, cin=1 → sum=1001, carry=0, ovf=1.
- Wrap-around:
  - a=1111, b=0001, cin=0 → sum=0000, carry=1, ovf=0.
  - a=1111, b=1111, cin=1 → sum=1111, carry=1, ovf=0.
- Full propagate chain:
  - a=1010, b=0101, cin=0 → sum=1111, carry=0, prop=1.
  - Same operands with cin=1 → sum=0000, carry=1, prop=1.
- Hold and reset priority:
  - Drop in_valid after a result → outputs hold their values, out_valid=0 next cycle.
  - rst_n=0 together with in_valid=1 → all outputs 0.
- Exhaustive random check, both builds: all 512 combinations of a, b and cin, streamed back-to-back → each result equals a+b+cin, arriving at latency 1 or 2 cycles depending on the build.

Source files
------------

// File: rtl/propagate_adder.sv
// ---------------------------------------------------------------------------
// propagate_adder
//
// Registered carry-propagate adder. It computes a + b + cin and registers
// four results: the sum, the carry-out, signed overflow and a
// group-propagate flag. Carries are formed from per-bit propagate and
// generate terms. Within each 4-bit group every carry is a flat lookahead
// equation, and the group carry-outs ripple from one group to the next. When
// WIDTH is not a multiple of 4, the last group is a truncated group.
//
// Optional build macro:
//   PROPAGATE_ADDER_IN_REG_EN  Registers a, b, cin and in_valid before the
//                              adder, so latency becomes 2 cycles. When the
//                              macro is undefined, latency is 1 cycle.
//
// Parameters:
//   WIDTH      operand and sum width (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in
//   out_valid  registered outputs hold a new result (high for one cycle)
//   sum        (a + b + cin) mod 2^WIDTH
//   carry      carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB ^ carry out of MSB)
//   prop       &(a ^ b), independent of cin
// ---------------------------------------------------------------------------
module propagate_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             prop
);

  // Operands as seen by the adder, either straight from the ports or from
  // the optional input register stage.
  logic [WIDTH-1:0] a_stage;
  logic [WIDTH-1:0] b_stage;
  logic             cin_stage;
  logic             valid_stage;

`ifdef PROPAGATE_ADDER_IN_REG_EN
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;
  logic             valid_reg;

  // Operand registers load only on valid cycles. A bubble leaves them holding
  // their old values, just as the output stage does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        a_reg   <= a;
        b_reg   <= b;
        cin_reg <= cin;
      end
    end
  end

  assign a_stage     = a_reg;
  assign b_stage     = b_reg;
  assign cin_stage   = cin_reg;
  assign valid_stage = valid_reg;
`else
  assign a_stage     = a;
  assign b_stage     = b;
  assign cin_stage   = cin;
  assign valid_stage = in_valid;
`endif

  // Per-bit propagate and generate terms.
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
    assign p[gi] = a_stage[gi] ^ b_stage[gi];
    assign g[gi] = a_stage[gi] & b_stage[gi];
  end

  // Carry vector: c[0] is cin, and c[i+1] is the carry out of bit i.
  // The carry for bit i is a sum of products that uses only p/g bits from
  // its own 4-bit group plus that group's carry-in c[base]. This keeps the
  // depth inside a group flat. Only c[base] ripples between groups.
  // The masked constant-bound loops unroll into one lookahead equation
  // per bit.
  logic [WIDTH:0] c;

  always_comb begin
    int   base;
    logic cin_term;
    logic gen_term;
    logic c_bit;
    c        = '0;
    c[0]     = cin_stage;
    base     = 0;
    cin_term = 1'b0;
    gen_term = 1'b0;
    c_bit    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      base = (i / 4) * 4;
      // Group carry-in propagated through bits base..i.
      cin_term = c[base];
      for (int m = 0; m < WIDTH; m++) begin
        if (m >= base && m <= i) cin_term = cin_term & p[m];
      end
      c_bit = cin_term;
      // Carry generated at bit j and propagated through bits j+1..i.
      for (int j = 0; j < WIDTH; j++) begin
        if (j >= base && j <= i) begin
          gen_term = g[j];
          for (int m = 0; m < WIDTH; m++) begin
            if (m > j && m <= i) gen_term = gen_term & p[m];
          end
          c_bit = c_bit | gen_term;
        end
      end
      c[i+1] = c_bit;
    end
  end

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;
  logic             ovf_next;
  logic             prop_next;

  assign sum_next   = p ^ c[WIDTH-1:0];
  assign carry_next = c[WIDTH];
  // When WIDTH = 1, c[WIDTH-1] is cin, so this expression also gives
  // cin ^ carry.
  assign ovf_next   = c[WIDTH-1] ^ c[WIDTH];
  assign prop_next  = &p;

  // Result registers. Reset wins over in_valid. A bubble holds the previous
  // result and drops out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      prop      <= 1'b0;
    end else begin
      out_valid <= valid_stage;
      if (valid_stage) begin
        sum   <= sum_next;
        carry <= carry_next;
        ovf   <= ovf_next;
        prop  <= prop_next;
      end
    end
  end

endmodule

// File: tb/tb_propagate_adder.sv
// ---------------------------------------------------------------------------
// tb_propagate_adder
//
// Self-checking bench for propagate_adder with WIDTH = 4.
//
// A behavioural model predicts the outputs after every clock edge. It uses
// integer arithmetic to form a + b + cin. It flags overflow when the signed
// sum falls outside the 4-bit range, and sets prop when a ^ b is all ones.
// A delay line of length LAT tracks latency, holding and reset.
//
// The run covers these phases: reset, a set of directed vectors compared
// against constants, hold, reset priority, an exhaustive back-to-back sweep,
// and a random phase.
// ---------------------------------------------------------------------------
module tb_propagate_adder;

  localparam int W = 4;
`ifdef PROPAGATE_ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;
  logic         prop;

  propagate_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf),
    .prop      (prop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         p;
  } ent_t;

  int total = 0;
  int bad   = 0;

  ent_t pipe[$];
  ent_t held;
  logic exp_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic ent_t ref_add(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc);
    ent_t e;
    int   full;
    int   sa;
    int   sb;
    int   ss;
    full = int'(ta) + int'(tb) + int'(tc);
    sa   = (int'(ta) >= (1 << (W-1))) ? int'(ta) - (1 << W) : int'(ta);
    sb   = (int'(tb) >= (1 << (W-1))) ? int'(tb) - (1 << W) : int'(tb);
    ss   = sa + sb + int'(tc);
    e.v  = 1'b1;
    e.s  = W'(full % (1 << W));
    e.c  = (full >= (1 << W));
    e.o  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    e.p  = ((ta ^ tb) == {W{1'b1}});
    return e;
  endfunction

  task automatic model_reset();
    pipe = {};
    for (int k = 0; k < LAT - 1; k++) pipe.push_back('0);
    held      = '0;
    exp_valid = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model past the rising edge,
  // then compare every output.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] ta,
                      input logic [W-1:0] tb, input logic tc);
    ent_t e;
    @(negedge clk);
    rst_n    = ~rst;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      e   = v ? ref_add(ta, tb, tc) : ent_t'(0);
      pipe.push_back(e);
      e   = pipe.pop_front();
      exp_valid = e.v;
      if (e.v) held = e;
    end
    #1;
    $display("cyc rst=%0b v=%0b a=%h b=%h cin=%0b -> ov=%0b sum=%h c=%0b o=%0b p=%0b",
             rst, v, ta, tb, tc, out_valid, sum, carry, ovf, prop);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("sum",       32'(sum),       32'(held.s));
    check("carry",     32'(carry),     32'(held.c));
    check("ovf",       32'(ovf),       32'(held.o));
    check("prop",      32'(prop),      32'(held.p));
  endtask

  // Directed vectors: a, b, cin, expected sum, carry, ovf, prop.
  typedef struct packed {
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         dc;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic         ep;
  } dir_t;

  dir_t dirs [7];

  initial begin
    dirs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    dirs[1] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0};
    dirs[2] = '{4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0};
    dirs[3] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
    dirs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    dirs[5] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1};
    dirs[6] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    model_reset();

    // Reset for two cycles.
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);

    // Directed vectors, each checked against constants once it has emerged.
    for (int d = 0; d < 7; d++) begin
      step(1'b0, 1'b1, dirs[d].da, dirs[d].db, dirs[d].dc);
      for (int k = 0; k < LAT - 1; k++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      check("dir_valid", 32'(out_valid), 32'd1);
      check("dir_sum",   32'(sum),       32'(dirs[d].es));
      check("dir_carry", 32'(carry),     32'(dirs[d].ec));
      check("dir_ovf",   32'(ovf),       32'(dirs[d].eo));
      check("dir_prop",  32'(prop),      32'(dirs[d].ep));
    end

    // Hold: drop in_valid with garbage on the operands.
    step(1'b0, 1'b0, 4'h7, 4'h7, 1'b1);
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_sum",   32'(sum),       32'(dirs[6].es));
    check("hold_carry", 32'(carry),     32'(dirs[6].ec));

    // Reset has priority over in_valid.
    step(1'b0, 1'b1, 4'h5, 4'h3, 1'b1);
    step(1'b1, 1'b1, 4'h9, 4'h9, 1'b1);
    check("rstprio_valid", 32'(out_valid), 32'd0);
    check("rstprio_sum",   32'(sum),       32'd0);
    check("rstprio_carry", 32'(carry),     32'd0);

    // Exhaustive sweep, streamed back-to-back.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      step(1'b0, 1'b1, iv[3:0], iv[7:4], iv[8]);
    end

    // Random phase: bubbles and occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom), 1'($urandom));
    end

    // Drain.
    for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
